// File: rtl/plb_slave_mem_model_if.sv
// plb_slave_mem_model_if
//
// Groups the PLB master request/write-data signals and the slave response
// signals that run between the PLB master under test and the slave memory
// model.
//
// Master -> slave : M_request, M_abort, M_RNW, M_ABus[0:31], M_size[0:3],
//                   M_BE[0:7], M_wrDBus[0:63], M_wrBurst, M_rdBurst
// Slave -> master : PLB_MAddrAck, PLB_MSSize[0:1], PLB_MRearbitrate,
//                   PLB_MBusy, PLB_MErr, PLB_MWrDAck, PLB_MWrBTerm,
//                   PLB_MRdDAck, PLB_MRdDBus[0:63], PLB_MRdWdAddr[0:3],
//                   PLB_MRdBTerm
//
// All vectors use the PLB big-endian numbering: bit 0 is the most
// significant bit, and M_BE[0] qualifies data bits 0:7.
interface plb_slave_mem_model_if;
    logic        M_request;
    logic        M_abort;
    logic        M_RNW;
    logic [0:31] M_ABus;
    logic [0:3]  M_size;
    logic [0:7]  M_BE;
    logic [0:63] M_wrDBus;
    logic        M_wrBurst;
    logic        M_rdBurst;

    logic        PLB_MAddrAck;
    logic [0:1]  PLB_MSSize;
    logic        PLB_MRearbitrate;
    logic        PLB_MBusy;
    logic        PLB_MErr;
    logic        PLB_MWrDAck;
    logic        PLB_MWrBTerm;
    logic        PLB_MRdDAck;
    logic [0:63] PLB_MRdDBus;
    logic [0:3]  PLB_MRdWdAddr;
    logic        PLB_MRdBTerm;

    modport master (
        output M_request, M_abort, M_RNW, M_ABus, M_size, M_BE, M_wrDBus,
               M_wrBurst, M_rdBurst,
        input  PLB_MAddrAck, PLB_MSSize, PLB_MRearbitrate, PLB_MBusy,
               PLB_MErr, PLB_MWrDAck, PLB_MWrBTerm, PLB_MRdDAck,
               PLB_MRdDBus, PLB_MRdWdAddr, PLB_MRdBTerm
    );

    modport slave (
        input  M_request, M_abort, M_RNW, M_ABus, M_size, M_BE, M_wrDBus,
               M_wrBurst, M_rdBurst,
        output PLB_MAddrAck, PLB_MSSize, PLB_MRearbitrate, PLB_MBusy,
               PLB_MErr, PLB_MWrDAck, PLB_MWrBTerm, PLB_MRdDAck,
               PLB_MRdDBus, PLB_MRdWdAddr, PLB_MRdBTerm
    );
endinterface

// File: rtl/plb_slave_mem_model.sv
// plb_slave_mem_model
//
// Synthesizable PLB slave memory that stands in for the bus, arbiter and
// slave in front of a PLB master under test. It accepts single transfers and
// 2/4/8-beat line bursts on the 64-bit big-endian data bus, applies byte
// enables on single writes, and returns read data after RD_LATENCY cycles.
//
// Parameters:
//   ADDR_BASE  - byte base address of the window, aligned to the window size
//   DEPTH_LOG2 - log2 of the number of 64-bit doublewords (>= 3)
//   RD_LATENCY - cycles from AddrAck to first RdDAck, 1..7
//
// Ports:
//   sys_clk_pin - clock, everything on the rising edge
//   sys_rst_pin - synchronous active-high reset (memory contents are kept)
//   bus         - slave side of plb_slave_mem_model_if
module plb_slave_mem_model #(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 9,
    parameter int          RD_LATENCY = 2
) (
    input logic                  sys_clk_pin,
    input logic                  sys_rst_pin,
    plb_slave_mem_model_if.slave bus
);

    localparam int          DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH) << 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WDATA,
        S_RWAIT,
        S_RDATA,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            beat_q, beat_d;
    logic [2:0]            wait_q, wait_d;
    logic                  rnw_q, rnw_d;
    logic                  err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [0:7]            be_q, be_d;
    logic [DEPTH_LOG2-1:0] index_q, index_d;

    logic [0:63]           mem [DEPTH];
    logic [0:63]           rd_data_q;

    // Request decode, evaluated every cycle but only used in IDLE.
    logic [31:0]           req_addr;
    logic [3:0]            req_size;
    logic [31:0]           req_offset;
    logic                  req_in_window;
    logic                  req_size_ok;
    logic [2:0]            req_last;
    logic [DEPTH_LOG2-1:0] req_index;

    logic [2:0]            last_beat;
    logic                  wr_ack;
    logic                  rd_ack;
    logic [0:7]            wr_be;
    logic [DEPTH_LOG2-1:0] wr_index;
    logic [DEPTH_LOG2-1:0] rd_index;

    // The burst qualifiers carry no information this model needs; the beat
    // count comes from M_size alone.
    logic                  unused_burst_quals;
    assign unused_burst_quals = bus.M_wrBurst | bus.M_rdBurst;

    assign req_addr      = bus.M_ABus;
    assign req_size      = bus.M_size;
    // Addresses below the base wrap to a large offset and fail the window test.
    assign req_offset    = req_addr - ADDR_BASE;
    assign req_in_window = {1'b0, req_offset} < WINDOW_BYTES;
    assign req_size_ok   = (req_size[3:2] == 2'b00);
    // Beats minus one doubles as the mask that aligns bursts to the line base.
    assign req_last      = (3'd1 << req_size[1:0]) - 3'd1;
    assign req_index     = req_offset[DEPTH_LOG2+2:3] & ~DEPTH_LOG2'(req_last);

    assign last_beat = (3'd1 << size_q) - 3'd1;
    assign wr_ack    = (state_q == S_WDATA);
    assign rd_ack    = (state_q == S_RDATA);
    // Bursts always write full doublewords; only singles honour M_BE.
    assign wr_be     = (size_q == 2'd0) ? be_q : 8'hFF;
    assign wr_index  = index_q + DEPTH_LOG2'(beat_q);

    // The memory read is registered, so the address runs one beat ahead of
    // the acknowledge: beat 0 is fetched in the cycle before RDATA starts,
    // and during beat b the fetch is for beat b+1.
    always_comb begin
        rd_index = index_q;
        if (rd_ack) begin
            rd_index = index_q + DEPTH_LOG2'(beat_q) + DEPTH_LOG2'(1);
        end
    end

    // Next-state logic: capture the request in IDLE, then walk through the
    // address ack, optional read wait and the data beats.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wait_d  = wait_q;
        rnw_d   = rnw_q;
        err_d   = err_q;
        size_d  = size_q;
        be_d    = be_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (bus.M_request && !bus.M_abort) begin
                    rnw_d   = bus.M_RNW;
                    err_d   = !(req_size_ok && req_in_window);
                    size_d  = req_size[1:0];
                    be_d    = bus.M_BE;
                    index_d = req_index;
                    beat_d  = 3'd0;
                    wait_d  = 3'd0;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (err_q) begin
                    state_d = S_ERR;
                end else if (!rnw_q) begin
                    state_d = S_WDATA;
                end else if (RD_LATENCY <= 1) begin
                    state_d = S_RDATA;
                end else begin
                    state_d = S_RWAIT;
                end
            end
            S_WDATA, S_RDATA: begin
                if (beat_q == last_beat) begin
                    beat_d  = 3'd0;
                    state_d = S_IDLE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            S_RWAIT: begin
                // ACK already accounts for one latency cycle.
                if (wait_q == 3'(RD_LATENCY - 2)) begin
                    wait_d  = 3'd0;
                    state_d = S_RDATA;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge sys_clk_pin) begin
        if (sys_rst_pin) begin
            state_q <= S_IDLE;
            beat_q  <= 3'd0;
            wait_q  <= 3'd0;
            rnw_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'd0;
            be_q    <= 8'h00;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            rnw_q   <= rnw_d;
            err_q   <= err_d;
            size_q  <= size_d;
            be_q    <= be_d;
            index_q <= index_d;
        end
    end

    // Memory array: byte-lane writes, registered read. Not cleared by reset.
    always_ff @(posedge sys_clk_pin) begin
        if (!sys_rst_pin && wr_ack) begin
            for (int i = 0; i < 8; i++) begin
                if (wr_be[i]) begin
                    mem[wr_index][8*i +: 8] <= bus.M_wrDBus[8*i +: 8];
                end
            end
        end
        rd_data_q <= mem[rd_index];
    end

    assign bus.PLB_MAddrAck     = (state_q == S_ACK);
    assign bus.PLB_MSSize       = (state_q == S_ACK) ? 2'b01 : 2'b00;
    assign bus.PLB_MRearbitrate = 1'b0;
    assign bus.PLB_MBusy        = state_q inside {S_ACK, S_WDATA, S_RWAIT, S_RDATA};
    assign bus.PLB_MErr         = (state_q == S_ERR);
    assign bus.PLB_MWrDAck      = wr_ack;
    assign bus.PLB_MWrBTerm     = wr_ack && (size_q != 2'd0) && (beat_q == last_beat);
    assign bus.PLB_MRdDAck      = rd_ack;
    assign bus.PLB_MRdDBus      = rd_ack ? rd_data_q : 64'd0;
    assign bus.PLB_MRdWdAddr    = rd_ack ? {beat_q, 1'b0} : 4'd0;
    assign bus.PLB_MRdBTerm     = rd_ack && (size_q != 2'd0) && (beat_q == last_beat);

endmodule

// File: tb/tb_plb_slave_mem_model.sv
// tb_plb_slave_mem_model
//
// Drives plb_slave_mem_model as a PLB master would. A shadow memory holds
// what the slave should contain; expected read beats are queued when a read
// is issued and popped as RdDAck beats arrive. Two extra instances built with
// RD_LATENCY 1 and 7 exercise the latency extremes.
`timescale 1ns/1ps
module tb_plb_slave_mem_model;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int          LAT  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    plb_slave_mem_model_if bus ();
    plb_slave_mem_model_if bus_l1 ();
    plb_slave_mem_model_if bus_l7 ();

    plb_slave_mem_model #(.ADDR_BASE(BASE), .DEPTH_LOG2(9), .RD_LATENCY(LAT)) dut (
        .sys_clk_pin(clk), .sys_rst_pin(rst), .bus(bus.slave));
    plb_slave_mem_model #(.ADDR_BASE(32'h0), .DEPTH_LOG2(9), .RD_LATENCY(1)) dut_l1 (
        .sys_clk_pin(clk), .sys_rst_pin(rst), .bus(bus_l1.slave));
    plb_slave_mem_model #(.ADDR_BASE(32'h0), .DEPTH_LOG2(9), .RD_LATENCY(7)) dut_l7 (
        .sys_clk_pin(clk), .sys_rst_pin(rst), .bus(bus_l7.slave));

    int checks   = 0;
    int failures = 0;

    logic [63:0] model_mem [512];
    logic [63:0] exp_q [$];
    logic [63:0] wdata_arr [8];

    int r_addrack_n, r_addrack_c, r_err_n, r_err_c;
    int r_wack_n, r_wack_first, r_wack_last, r_wbterm_n, r_wbterm_c;
    int r_rack_n, r_rack_first, r_rack_last, r_rbterm_n, r_rbterm_c;
    int r_busy_last, r_side_bad, r_leak;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [77:0] out_vec();
        return {bus.PLB_MAddrAck, bus.PLB_MSSize, bus.PLB_MRearbitrate, bus.PLB_MBusy,
                bus.PLB_MErr, bus.PLB_MWrDAck, bus.PLB_MWrBTerm, bus.PLB_MRdDAck,
                bus.PLB_MRdDBus, bus.PLB_MRdWdAddr, bus.PLB_MRdBTerm};
    endfunction

    function automatic int line_base(input logic [31:0] addr, input logic [3:0] size);
        int n;
        n = 1 << size;
        return (int'((addr - BASE) >> 3) & 511) & ~(n - 1);
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [3:0] size, input logic [7:0] be);
        int b;
        b = line_base(addr, size);
        if (size == 4'd0) begin
            for (int i = 0; i < 8; i++)
                if (be[7-i]) model_mem[b][63-8*i -: 8] = wdata_arr[0][63-8*i -: 8];
        end else begin
            for (int k = 0; k < (1 << size); k++) model_mem[b+k] = wdata_arr[k];
        end
    endtask

    task automatic push_read(input logic [31:0] addr, input logic [3:0] size);
        int b;
        b = line_base(addr, size);
        for (int k = 0; k < (1 << size); k++) exp_q.push_back(model_mem[b+k]);
    endtask

    // Issues one request (cycle 0) and watches ncyc further cycles, recording
    // when each response appears. Read beats are checked against the queue.
    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] size,
                        input logic [7:0] be, input int ncyc);
        int rbeat, wbeat;
        logic [63:0] exp;
        r_addrack_n = 0; r_addrack_c = -1; r_err_n = 0; r_err_c = -1;
        r_wack_n = 0; r_wack_first = -1; r_wack_last = -1; r_wbterm_n = 0; r_wbterm_c = -1;
        r_rack_n = 0; r_rack_first = -1; r_rack_last = -1; r_rbterm_n = 0; r_rbterm_c = -1;
        r_busy_last = -1; r_side_bad = 0; r_leak = 0;
        rbeat = 0; wbeat = 0;
        step();
        bus.M_request = 1'b1; bus.M_RNW = rnw; bus.M_ABus = addr;
        bus.M_size = size; bus.M_BE = be; bus.M_wrDBus = wdata_arr[0];
        for (int c = 1; c <= ncyc; c++) begin
            step();
            if (wbeat < 8) bus.M_wrDBus = wdata_arr[wbeat];
            if (bus.PLB_MAddrAck) begin
                r_addrack_n++;
                if (r_addrack_c < 0) r_addrack_c = c;
                bus.M_request = 1'b0;
            end
            if (bus.PLB_MSSize !== (bus.PLB_MAddrAck ? 2'b01 : 2'b00) || bus.PLB_MRearbitrate !== 1'b0)
                r_side_bad++;
            if (bus.PLB_MErr) begin r_err_n++; if (r_err_c < 0) r_err_c = c; end
            if (bus.PLB_MWrDAck) begin
                r_wack_n++; r_wack_last = c; wbeat++;
                if (r_wack_first < 0) r_wack_first = c;
            end
            if (bus.PLB_MWrBTerm) begin r_wbterm_n++; r_wbterm_c = c; end
            if (bus.PLB_MRdBTerm) begin r_rbterm_n++; r_rbterm_c = c; end
            if (bus.PLB_MBusy) r_busy_last = c;
            if (bus.PLB_MRdDAck) begin
                r_rack_n++; r_rack_last = c;
                if (r_rack_first < 0) r_rack_first = c;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rd_unexpected_beat got=%h required=no beat", bus.PLB_MRdDBus);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.PLB_MRdDBus !== exp) begin
                        failures++;
                        $display("[TB] FAIL rd_data beat=%0d got=%h required=%h", rbeat, bus.PLB_MRdDBus, exp);
                    end
                end
                checks++;
                if (bus.PLB_MRdWdAddr !== 4'(2 * rbeat)) begin
                    failures++;
                    $display("[TB] FAIL rd_wdaddr beat=%0d got=%0d required=%0d", rbeat, bus.PLB_MRdWdAddr, 2 * rbeat);
                end
                rbeat++;
            end else if (bus.PLB_MRdDBus !== 64'd0) begin
                r_leak++;
            end
        end
        bus.M_request = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        step(); step(); step();
        checks++;
        if (out_vec() !== 78'd0) begin
            failures++; $display("[TB] FAIL reset_outputs got=%h required=0", out_vec());
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_vec() !== 78'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL idle_outputs got=%0d nonzero cycles required=0", bad); end
        bus.M_request = 1'b1; bus.M_abort = 1'b1; bus.M_RNW = 1'b1; bus.M_ABus = BASE;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 2) begin bus.M_request = 1'b0; bus.M_abort = 1'b0; end
            if (bus.PLB_MAddrAck || bus.PLB_MBusy) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL abort_ignored got=%0d ack/busy cycles required=0", bad); end
    endtask

    task automatic test_single_rw();
        wdata_arr[0] = 64'd0;
        xfer(1'b0, BASE + 32'h10, 4'd0, 8'hFF, 5);
        model_write(BASE + 32'h10, 4'd0, 8'hFF);
        wdata_arr[0] = 64'h0123_4567_89AB_CDEF;
        xfer(1'b0, BASE + 32'h10, 4'd0, 8'hF0, 5);
        model_write(BASE + 32'h10, 4'd0, 8'hF0);
        checks++;
        if (r_addrack_c !== 1 || r_addrack_n !== 1) begin failures++; $display("[TB] FAIL wr_addrack got=c%0d/n%0d required=c1/n1", r_addrack_c, r_addrack_n); end
        checks++;
        if (r_wack_first !== 2 || r_wack_n !== 1) begin failures++; $display("[TB] FAIL wr_single_dack got=c%0d/n%0d required=c2/n1", r_wack_first, r_wack_n); end
        checks++;
        if (r_wbterm_n !== 0 || r_busy_last !== 2) begin failures++; $display("[TB] FAIL wr_single_term_busy got=term%0d/busy%0d required=term0/busy2", r_wbterm_n, r_busy_last); end
        checks++;
        if (r_side_bad !== 0) begin failures++; $display("[TB] FAIL sssize_rearb got=%0d bad cycles required=0", r_side_bad); end
        push_read(BASE + 32'h10, 4'd0);
        xfer(1'b1, BASE + 32'h10, 4'd0, 8'hFF, 8);
        checks++;
        if (r_addrack_c !== 1) begin failures++; $display("[TB] FAIL rd_addrack got=c%0d required=c1", r_addrack_c); end
        checks++;
        if (r_rack_first !== 1 + LAT || r_rack_n !== 1) begin failures++; $display("[TB] FAIL rd_single_dack got=c%0d/n%0d required=c%0d/n1", r_rack_first, r_rack_n, 1 + LAT); end
        checks++;
        if (r_rbterm_n !== 0 || r_busy_last !== 1 + LAT || r_leak !== 0) begin failures++; $display("[TB] FAIL rd_single_misc got=term%0d/busy%0d/leak%0d required=0/%0d/0", r_rbterm_n, r_busy_last, r_leak, 1 + LAT); end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 8; i++) wdata_arr[i] = {$urandom, $urandom};
        xfer(1'b0, BASE + 32'h48, 4'b0011, 8'h0F, 12);
        model_write(BASE + 32'h48, 4'b0011, 8'h0F);
        checks++;
        if (r_wack_n !== 8 || r_wack_first !== 2 || r_wack_last !== 9) begin failures++; $display("[TB] FAIL burst8_wdack got=n%0d c%0d..c%0d required=n8 c2..c9", r_wack_n, r_wack_first, r_wack_last); end
        checks++;
        if (r_wbterm_n !== 1 || r_wbterm_c !== 9 || r_busy_last !== 9) begin failures++; $display("[TB] FAIL burst8_wbterm got=n%0d c%0d busy%0d required=n1 c9 busy9", r_wbterm_n, r_wbterm_c, r_busy_last); end
        push_read(BASE + 32'h78, 4'b0011);
        xfer(1'b1, BASE + 32'h78, 4'b0011, 8'hFF, 14);
        checks++;
        if (r_rack_n !== 8 || r_rack_first !== 1 + LAT || r_rack_last !== LAT + 8) begin failures++; $display("[TB] FAIL burst8_rdack got=n%0d c%0d..c%0d required=n8 c%0d..c%0d", r_rack_n, r_rack_first, r_rack_last, 1 + LAT, LAT + 8); end
        checks++;
        if (r_rbterm_n !== 1 || r_rbterm_c !== LAT + 8 || r_busy_last !== LAT + 8) begin failures++; $display("[TB] FAIL burst8_rbterm got=n%0d c%0d busy%0d required=n1 c%0d", r_rbterm_n, r_rbterm_c, r_busy_last, LAT + 8); end
        checks++;
        if (exp_q.size() !== 0 || r_leak !== 0) begin failures++; $display("[TB] FAIL burst8_drain got=left%0d leak%0d required=0/0", exp_q.size(), r_leak); end
        for (int i = 0; i < 4; i++) wdata_arr[i] = {$urandom, $urandom};
        xfer(1'b0, BASE + 32'h8C, 4'b0010, 8'h00, 10);
        model_write(BASE + 32'h8C, 4'b0010, 8'h00);
        checks++;
        if (r_wack_n !== 4 || r_wbterm_c !== 5) begin failures++; $display("[TB] FAIL burst4_wr got=n%0d term_c%0d required=n4 c5", r_wack_n, r_wbterm_c); end
        push_read(BASE + 32'h98, 4'b0001);
        xfer(1'b1, BASE + 32'h98, 4'b0001, 8'hFF, 10);
        checks++;
        if (r_rack_n !== 2 || r_rbterm_c !== LAT + 2 || exp_q.size() !== 0) begin failures++; $display("[TB] FAIL burst2_rd got=n%0d term_c%0d left%0d required=n2 c%0d 0", r_rack_n, r_rbterm_c, exp_q.size(), LAT + 2); end
    endtask

    task automatic test_error();
        wdata_arr[0] = 64'hDEAD_BEEF_CAFE_F00D;
        xfer(1'b0, BASE, 4'd0, 8'hFF, 5);
        model_write(BASE, 4'd0, 8'hFF);
        wdata_arr[0] = 64'h1111_2222_3333_4444;
        xfer(1'b0, BASE + 32'd4096, 4'd0, 8'hFF, 6);
        checks++;
        if (r_addrack_c !== 1 || r_err_n !== 1 || r_err_c !== 2) begin failures++; $display("[TB] FAIL err_window got=ack%0d err_n%0d err_c%0d required=1/1/2", r_addrack_c, r_err_n, r_err_c); end
        checks++;
        if (r_wack_n !== 0 || r_busy_last !== 1) begin failures++; $display("[TB] FAIL err_window_nodata got=wack%0d busy%0d required=0/1", r_wack_n, r_busy_last); end
        xfer(1'b1, BASE + 32'h10, 4'b1010, 8'hFF, 8);
        checks++;
        if (r_err_c !== 2 || r_rack_n !== 0) begin failures++; $display("[TB] FAIL err_size_rd got=err_c%0d rack%0d required=2/0", r_err_c, r_rack_n); end
        xfer(1'b0, BASE + 32'h10, 4'b1010, 8'hFF, 6);
        checks++;
        if (r_err_n !== 1 || r_wack_n !== 0) begin failures++; $display("[TB] FAIL err_size_wr got=err%0d wack%0d required=1/0", r_err_n, r_wack_n); end
        xfer(1'b0, BASE - 32'd8, 4'd0, 8'hFF, 6);
        checks++;
        if (r_err_n !== 1 || r_wack_n !== 0) begin failures++; $display("[TB] FAIL err_below_base got=err%0d wack%0d required=1/0", r_err_n, r_wack_n); end
        push_read(BASE, 4'd0);
        xfer(1'b1, BASE, 4'd0, 8'hFF, 8);
        push_read(BASE + 32'h10, 4'd0);
        xfer(1'b1, BASE + 32'h10, 4'd0, 8'hFF, 8);
        checks++;
        if (r_rack_n !== 1 || exp_q.size() !== 0) begin failures++; $display("[TB] FAIL err_readback got=rack%0d left%0d required=1/0", r_rack_n, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        wdata_arr[0] = {$urandom, $urandom};
        xfer(1'b0, BASE + 32'h100, 4'd0, 8'hFF, 2);
        model_write(BASE + 32'h100, 4'd0, 8'hFF);
        checks++;
        if (r_wack_first !== 2) begin failures++; $display("[TB] FAIL b2b_wr got=c%0d required=c2", r_wack_first); end
        push_read(BASE + 32'h100, 4'd0);
        xfer(1'b1, BASE + 32'h100, 4'd0, 8'hFF, 8);
        checks++;
        if (r_addrack_c !== 1 || r_rack_n !== 1) begin failures++; $display("[TB] FAIL b2b_rd got=ack_c%0d rack%0d required=1/1", r_addrack_c, r_rack_n); end
    endtask

    task automatic test_reset_mid();
        int cnt, bad;
        cnt = 0;
        step();
        bus.M_request = 1'b1; bus.M_RNW = 1'b1; bus.M_ABus = BASE + 32'h40; bus.M_size = 4'b0010;
        for (int c = 1; c <= 20 && cnt < 3; c++) begin
            step();
            if (bus.PLB_MAddrAck) bus.M_request = 1'b0;
            if (bus.PLB_MRdDAck) cnt++;
        end
        checks++;
        if (cnt !== 3) begin failures++; $display("[TB] FAIL rstmid_reach_beat3 got=%0d required=3", cnt); end
        bus.M_request = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if (out_vec() !== 78'd0) begin failures++; $display("[TB] FAIL rstmid_outputs got=%h required=0", out_vec()); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_vec() !== 78'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin failures++; $display("[TB] FAIL rstmid_quiet got=%0d active cycles required=0", bad); end
        push_read(BASE + 32'h48, 4'd0);
        xfer(1'b1, BASE + 32'h48, 4'd0, 8'hFF, 8);
        checks++;
        if (r_addrack_c !== 1 || r_rack_n !== 1) begin failures++; $display("[TB] FAIL rstmid_recover got=ack_c%0d rack%0d required=1/1", r_addrack_c, r_rack_n); end
    endtask

    task automatic test_latency_variants();
        logic [63:0] d;
        int f1, f7, n1, n7;
        d = {$urandom, $urandom};
        f1 = -1; f7 = -1; n1 = 0; n7 = 0;
        step();
        bus_l1.M_request = 1'b1; bus_l1.M_RNW = 1'b0; bus_l1.M_ABus = 32'h20; bus_l1.M_size = 4'd0;
        bus_l1.M_BE = 8'hFF; bus_l1.M_wrDBus = d;
        bus_l7.M_request = 1'b1; bus_l7.M_RNW = 1'b0; bus_l7.M_ABus = 32'h20; bus_l7.M_size = 4'd0;
        bus_l7.M_BE = 8'hFF; bus_l7.M_wrDBus = d;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 1 || c == 5) begin bus_l1.M_request = 1'b0; bus_l7.M_request = 1'b0; end
            if (c == 4) begin
                bus_l1.M_request = 1'b1; bus_l1.M_RNW = 1'b1;
                bus_l7.M_request = 1'b1; bus_l7.M_RNW = 1'b1;
            end
            if (bus_l1.PLB_MRdDAck) begin
                n1++; if (f1 < 0) f1 = c;
                checks++;
                if (bus_l1.PLB_MRdDBus !== d) begin failures++; $display("[TB] FAIL lat1_data got=%h required=%h", bus_l1.PLB_MRdDBus, d); end
            end
            if (bus_l7.PLB_MRdDAck) begin
                n7++; if (f7 < 0) f7 = c;
                checks++;
                if (bus_l7.PLB_MRdDBus !== d) begin failures++; $display("[TB] FAIL lat7_data got=%h required=%h", bus_l7.PLB_MRdDBus, d); end
            end
        end
        checks++;
        if (f1 !== 6 || n1 !== 1) begin failures++; $display("[TB] FAIL lat1_first_dack got=c%0d/n%0d required=c6/n1", f1, n1); end
        checks++;
        if (f7 !== 12 || n7 !== 1) begin failures++; $display("[TB] FAIL lat7_first_dack got=c%0d/n%0d required=c12/n1", f7, n7); end
    endtask

    initial begin
        rst = 1'b1;
        bus.M_request = 1'b0; bus.M_abort = 1'b0; bus.M_RNW = 1'b0; bus.M_ABus = '0;
        bus.M_size = '0; bus.M_BE = '0; bus.M_wrDBus = '0; bus.M_wrBurst = 1'b0; bus.M_rdBurst = 1'b0;
        bus_l1.M_request = 1'b0; bus_l1.M_abort = 1'b0; bus_l1.M_RNW = 1'b0; bus_l1.M_ABus = '0;
        bus_l1.M_size = '0; bus_l1.M_BE = '0; bus_l1.M_wrDBus = '0; bus_l1.M_wrBurst = 1'b0; bus_l1.M_rdBurst = 1'b0;
        bus_l7.M_request = 1'b0; bus_l7.M_abort = 1'b0; bus_l7.M_RNW = 1'b0; bus_l7.M_ABus = '0;
        bus_l7.M_size = '0; bus_l7.M_BE = '0; bus_l7.M_wrDBus = '0; bus_l7.M_wrBurst = 1'b0; bus_l7.M_rdBurst = 1'b0;
        for (int i = 0; i < 512; i++) model_mem[i] = 64'd0;
        for (int i = 0; i < 8; i++) wdata_arr[i] = 64'd0;
        test_reset();
        test_single_rw();
        test_burst();
        test_error();
        test_back_to_back();
        test_reset_mid();
        test_latency_variants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout required=completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/plb_slave_mem_model.md
# plb_slave_mem_model

Synthesizable PLB slave memory that sits directly downstream of the PLB master under test, consuming its M_* request and write-data signals and driving the PLB_M* response signals back into it. It replaces the bus/arbiter/slave side in the PLB driver test harness. It supports single transfers and fixed-length line bursts on the 64-bit big-endian data bus, with byte-enable masked writes and programmable read latency.

## Interface
- ADDR_BASE, 32'h0000_0000, byte base address of the memory window (aligned to window size)
- DEPTH_LOG2, 9, log2 of depth in 64-bit doublewords (512 → 4 KB window)
- RD_LATENCY, 2, cycles from AddrAck to first RdDAck, legal range 1..7
- sys_clk_pin  in  1  sole clock, all logic on rising edge
- sys_rst_pin  in  1  reset, synchronous, active-high
- M_request  in  1  master request
- M_abort  in  1  request abort (same-cycle only)
- M_RNW  in  1  1 = read, 0 = write
- M_ABus  in  [0:31]  byte address
- M_size  in  [0:3]  transfer size code
- M_BE  in  [0:7]  byte enables, BE[0] → data bits 0:7
- M_wrDBus  in  [0:63]  write data
- M_wrBurst, M_rdBurst  in  1  burst qualifiers (sampled, not required)
- PLB_MAddrAck  out  1  address acknowledge pulse
- PLB_MSSize  out  [0:1]  slave size, 2'b01 during AddrAck, else 0
- PLB_MRearbitrate  out  1  constant 0
- PLB_MBusy  out  1  slave owns an outstanding transfer
- PLB_MErr  out  1  error pulse
- PLB_MWrDAck  out  1  write data acknowledge
- PLB_MWrBTerm  out  1  write burst terminate
- PLB_MRdDAck  out  1  read data valid
- PLB_MRdDBus  out  [0:63]  read data
- PLB_MRdWdAddr  out  [0:3]  32-bit word index of current read beat within line
- PLB_MRdBTerm  out  1  read burst terminate

## Operation
- Beat count N by M_size: 0000 → 1; 0001 → 2; 0010 → 4; 0011 → 8. Any other code is unsupported.
- In-window test: M_ABus[0:31] − ADDR_BASE < 8·2^DEPTH_LOG2.
- Index = (M_ABus − ADDR_BASE) >> 3. For N > 1, the index is aligned down to an N boundary and beats proceed linearly from line base. No wrap past line end.
- States: IDLE, ACK, WDATA, RWAIT, RDATA, ERR.
- IDLE: on M_request=1 and M_abort=0, capture RNW/index/size/BE and go to ACK. M_abort=1 means the request is ignored.
- ACK: drive PLB_MAddrAck=1 for one cycle and set PLB_MBusy=1.
  - If unsupported size or out of window, go to ERR.
  - Else write → WDATA; read → RWAIT.
- ERR: PLB_MErr=1 for one cycle, PLB_MBusy cleared, back to IDLE. No data phase occurs and memory is untouched.
- WDATA: PLB_MWrDAck=1 for N consecutive cycles.
  - Each acked cycle writes M_wrDBus into mem[index+beat], byte lanes masked by M_BE for single transfers; bursts write all 8 bytes.
  - PLB_MWrBTerm=1 on the last beat when N>1.
- RWAIT: counts RD_LATENCY−1 cycles, then goes to RDATA.
- RDATA: PLB_MRdDAck=1 for N consecutive cycles.
  - PLB_MRdDBus = mem[index+beat]; PLB_MRdDBus = 0 when RdDAck=0.
  - PLB_MRdWdAddr = 2·beat.
  - PLB_MRdBTerm=1 on the last beat when N>1.
- PLB_MBusy falls the cycle after the last data ack. Return to IDLE.
- Requests arriving while not IDLE are not acked; the master holds M_request.
- Memory contents are not cleared by reset.

## Timing
- Reset (sys_rst_pin=1 at a clock edge): all outputs 0, state IDLE, beat counter 0. Reset mid-transfer aborts it; no further acks follow, and partially written beats remain.
- Request sampled in IDLE in cycle t → AddrAck in t+1.
- Write: WrDAck in cycles t+2 .. t+1+N.
- Read: first RdDAck at t+1+RD_LATENCY, last at t+RD_LATENCY+N.
- Memory read is registered; the read address is presented one cycle before each RdDAck.
- Back-to-back: the next request can be sampled in the cycle after PLB_MBusy falls; minimum 2 idle cycles between AddrAcks of consecutive singles.
- Read-after-write to the same index returns the new data.

## Test plan
- Reset then idle 10 cycles → all outputs 0. A request with M_abort=1 → no AddrAck.
- Single write to ADDR_BASE+0x10, data 64'h0123_4567_89AB_CDEF, BE 8'hF0; then single read of the same address (prior contents 0) → RdDBus=64'h0123_4567_0000_0000, AddrAck at t+1, RdDAck at t+3 with RD_LATENCY=2.
- 8-beat write (M_size 0011) at ADDR_BASE+0x48 → aligned to index 8, WrDAck 8 cycles, WrBTerm on beat 8 only.
  - Then 8-beat read → data in order, RdWdAddr 0,2,…,14, RdBTerm on last beat, MBusy low the cycle after.
- Out-of-window address ADDR_BASE+4096 and size 1010 → AddrAck then MErr one cycle later, no DAcks, memory unchanged.
- Reset asserted during beat 3 of a 4-beat read → outputs 0 the next cycle. A subsequent request is acked normally.
- RD_LATENCY=1 and 7 builds → first RdDAck at t+2 and t+8 respectively.
